// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
package i2c_pkg;

    // Sequencer states: one address byte, then zero or more data bytes.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_XFER  = 3'd2,
        S_ACKW  = 3'd3,
        S_FIN   = 3'd4
    } seq_state_t;

    // Completion status reported to the register block.
    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_ADDR_NACK = 2'd1,
        ST_DATA_NACK = 2'd2
    } seq_status_t;

    // Level on the ACK bit as seen on SDA.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_seq_buf.sv
// DEPTH x 8 transfer buffer: one write port shared by host and sequencer,
// two asynchronous read ports (host and sequencer).
module i2c_seq_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_widx,
    input  logic [7:0]    i_host_wdata,
    input  logic          i_seq_we,
    input  logic [AW-1:0] i_seq_widx,
    input  logic [7:0]    i_seq_wdata,
    input  logic [AW-1:0] i_host_ridx,
    output logic [7:0]    o_host_rdata,
    input  logic [AW-1:0] i_seq_ridx,
    output logic [7:0]    o_seq_rdata
);

    logic [7:0]    r_mem [DEPTH];
    logic          w_we;
    logic [AW-1:0] w_widx;
    logic [7:0]    w_wdata;

    // Host writes are blocked while busy, so the two writers never collide;
    // the sequencer still takes priority.
    assign w_we    = i_seq_we | i_host_we;
    assign w_widx  = i_seq_we ? i_seq_widx  : i_host_widx;
    assign w_wdata = i_seq_we ? i_seq_wdata : i_host_wdata;

    // Register-file write port.
    // NOTE: storage has no reset so it maps onto plain flops/LUT-RAM; state
    // flops use non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    assign o_host_rdata = r_mem[i_host_ridx];
    assign o_seq_rdata  = r_mem[i_seq_ridx];

endmodule

// File: rtl/i2c_seq.sv
// I2C transaction sequencer: turns one host command plus a data buffer into
// a byte-by-byte conversation with the byte-level i2c driver.
module i2c_seq
    import i2c_pkg::*;
#(
    parameter int CLOCK_HZ = 27_000_000,
    parameter int BAUD     = 100_000,
    parameter int DEPTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_start,
    input  logic [6:0]                cmd_addr,
    input  logic                      cmd_rw,
    input  logic [$clog2(DEPTH):0]    cmd_len,
    input  logic                      buf_we,
    input  logic [$clog2(DEPTH)-1:0]  buf_widx,
    input  logic [7:0]                buf_wdata,
    input  logic [$clog2(DEPTH)-1:0]  buf_ridx,
    output logic [7:0]                buf_rdata,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                status,
    output logic [$clog2(DEPTH)-1:0]  nack_idx,
    output logic                      i2c_cnd_start,
    output logic                      i2c_cnd_stop,
    output logic                      i2c_rw,
    output logic [7:0]                i2c_tx_data,
    output logic                      i2c_tx_start,
    output logic                      i2c_tx_ack,
    input  logic                      i2c_tx_ready,
    input  logic [7:0]                i2c_rx_data,
    input  logic                      i2c_rx_ack
);

    localparam int BIT_CYCLES = CLOCK_HZ / BAUD;
    localparam int AW         = $clog2(DEPTH);
    localparam int LW         = AW + 1;
    localparam int WAIT_SHORT = BIT_CYCLES + 4;
    localparam int WAIT_LONG  = 2 * BIT_CYCLES + 4;
    localparam int WW         = $clog2(WAIT_LONG + 1);

    seq_state_t    r_state, w_next;
    seq_status_t   r_status;
    logic [6:0]    r_addr;
    logic          r_rw;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic          r_is_addr;
    logic          r_seen_low;
    logic [WW-1:0] r_wait;
    logic [AW-1:0] r_nack_idx;

    logic          w_accept;
    logic [LW-1:0] w_len_clamped;
    logic          w_in_byte;
    logic          w_last_byte;
    logic          w_drv_write;
    logic [WW-1:0] w_wait_limit;
    logic          w_wait_done;
    logic          w_nack;
    logic          w_seq_we;
    logic          w_host_we;
    logic [7:0]    w_seq_rdata;

    assign w_accept      = (r_state == S_IDLE) && cmd_start;
    assign w_len_clamped = (cmd_len > LW'(DEPTH)) ? LW'(DEPTH) : cmd_len;
    assign w_in_byte     = (r_state == S_ISSUE) || (r_state == S_XFER) || (r_state == S_ACKW);
    // idx + 1 == len at LW bits never wraps, unlike len - 1 with len == 0.
    assign w_last_byte   = r_is_addr ? (r_len == '0) : ((r_idx + LW'(1)) == r_len);
    assign w_drv_write   = r_is_addr || !r_rw;
    assign w_nack        = w_drv_write && i2c_rx_ack;
    assign w_wait_limit  = i2c_cnd_stop ? WW'(WAIT_SHORT - 1) : WW'(WAIT_LONG - 1);
    assign w_wait_done   = (r_state == S_ACKW) && (r_wait >= w_wait_limit);
    assign w_seq_we      = w_wait_done && !r_is_addr && r_rw;
    assign w_host_we     = buf_we && (r_state == S_IDLE);

    i2c_seq_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk          (clk),
        .i_host_we    (w_host_we),
        .i_host_widx  (buf_widx),
        .i_host_wdata (buf_wdata),
        .i_seq_we     (w_seq_we),
        .i_seq_widx   (r_idx[AW-1:0]),
        .i_seq_wdata  (i2c_rx_data),
        .i_host_ridx  (buf_ridx),
        .o_host_rdata (buf_rdata),
        .i_seq_ridx   (r_idx[AW-1:0]),
        .o_seq_rdata  (w_seq_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (cmd_start) w_next = S_ISSUE;
            S_ISSUE: w_next = S_XFER;
            S_XFER:  if (r_seen_low && i2c_tx_ready) w_next = S_ACKW;
            S_ACKW:  if (w_wait_done) w_next = (w_nack || w_last_byte) ? S_FIN : S_ISSUE;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, byte counter, handshake tracking and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_len      <= '0;
            r_idx      <= '0;
            r_is_addr  <= 1'b1;
            r_seen_low <= 1'b0;
            r_wait     <= '0;
            r_status   <= ST_OK;
            r_nack_idx <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= cmd_addr;
                r_rw       <= cmd_rw;
                r_len      <= w_len_clamped;
                r_idx      <= '0;
                r_is_addr  <= 1'b1;
                r_status   <= ST_OK;
                r_nack_idx <= '0;
            end

            if (r_state == S_ISSUE) begin
                r_seen_low <= 1'b0;
            end else if ((r_state == S_XFER) && !i2c_tx_ready) begin
                r_seen_low <= 1'b1;
            end

            if (r_state == S_ACKW) begin
                r_wait <= r_wait + WW'(1);
            end else begin
                r_wait <= '0;
            end

            if (w_wait_done) begin
                if (w_nack) begin
                    r_status <= r_is_addr ? ST_ADDR_NACK : ST_DATA_NACK;
                    if (!r_is_addr) begin
                        r_nack_idx <= r_idx[AW-1:0];
                    end
                end else if (!w_last_byte) begin
                    if (r_is_addr) begin
                        r_is_addr <= 1'b0;
                    end else begin
                        r_idx <= r_idx + LW'(1);
                    end
                end
            end
        end
    end

    // Driver-facing outputs, held steady from ISSUE through ACKW.
    always_comb begin
        i2c_cnd_start = 1'b0;
        i2c_cnd_stop  = 1'b0;
        i2c_rw        = 1'b0;
        i2c_tx_data   = 8'hFF;
        i2c_tx_start  = 1'b0;
        i2c_tx_ack    = I2C_NACK;
        if (w_in_byte) begin
            i2c_tx_start = (r_state == S_ISSUE);
            // A stale rx_ack early in ACKW is harmless: the driver samples
            // cnd_stop only at the end of the ACK bit.
            i2c_cnd_stop = w_last_byte || ((r_state == S_ACKW) && w_drv_write && i2c_rx_ack);
            if (r_is_addr) begin
                i2c_cnd_start = 1'b1;
                i2c_tx_data   = {r_addr, r_rw};
            end else begin
                i2c_rw = r_rw;
                if (r_rw) begin
                    i2c_tx_ack = w_last_byte ? I2C_NACK : I2C_ACK;
                end else begin
                    i2c_tx_data = w_seq_rdata;
                end
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);
    assign status   = r_status;
    assign nack_idx = r_nack_idx;

endmodule
